// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester command ports, the ALU drive/result bus and the
// response port of alu_arbiter.
//   master : requester + ALU side (drives commands and alu_out, receives grants and responses)
//   slave  : arbiter side (alu_arbiter)
// Optional macro ALU_ARB_LOCK_EN adds the reqN_lock signals.
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [1:0]        req0_op,    req1_op;
    logic [2:0]        req0_funct, req1_funct;
    logic [1:0]        req0_shamt, req1_shamt;
    logic [7:0]        req0_idata, req1_idata;
    logic [DATA_W-1:0] req0_reg1,  req1_reg1;
    logic [DATA_W-1:0] req0_reg2,  req1_reg2;
`ifdef ALU_ARB_LOCK_EN
    logic              req0_lock,  req1_lock;
`endif

    logic [1:0]        alu_op;
    logic [2:0]        alu_funct;
    logic [1:0]        alu_shamt;
    logic [7:0]        alu_idata;
    logic [DATA_W-1:0] alu_reg1, alu_reg2;
    logic [DATA_W-1:0] alu_out;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
`ifdef ALU_ARB_LOCK_EN
        output req0_lock, req1_lock,
`endif
        output req0_valid, req0_op, req0_funct, req0_shamt, req0_idata, req0_reg1, req0_reg2,
        output req1_valid, req1_op, req1_funct, req1_shamt, req1_idata, req1_reg1, req1_reg2,
        input  req0_ready, req1_ready,
        input  alu_op, alu_funct, alu_shamt, alu_idata, alu_reg1, alu_reg2,
        output alu_out,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
`ifdef ALU_ARB_LOCK_EN
        input  req0_lock, req1_lock,
`endif
        input  req0_valid, req0_op, req0_funct, req0_shamt, req0_idata, req0_reg1, req0_reg2,
        input  req1_valid, req1_op, req1_funct, req1_shamt, req1_idata, req1_reg1, req1_reg2,
        output req0_ready, req1_ready,
        output alu_op, alu_funct, alu_shamt, alu_idata, alu_reg1, alu_reg2,
        input  alu_out,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between the execute stage (id 0) and the
// multi-cycle/coprocessor unit (id 1) with round-robin arbitration. The granted command is
// driven onto the ALU combinationally; the result is registered and returned one cycle later
// tagged with the requester id. Illegal {op,funct} codes return data 0 with rsp_err set.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : alu_arbiter_if.slave (request ports, ALU bus, response port)
// Optional macro ALU_ARB_LOCK_EN: reqN_lock lets a requester hold ALU ownership for up to
// LOCK_MAX consecutive locked transfers.
module alu_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter bit          RESET_PTR = 1'b0,
    parameter int unsigned LOCK_MAX  = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    logic              rr_ptr_q, rr_ptr_d;
    logic              elig0, elig1;
    logic              gnt0, gnt1, xfer, gnt_id;
    logic              legal;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef ALU_ARB_LOCK_EN
    logic       own_q, own_d;
    logic       own_id_q, own_id_d;
    logic [2:0] lock_cnt_q, lock_cnt_d;
    logic [2:0] lock_cnt_inc;
    logic       gnt_lock;

    // An owner masks the other requester; a missing owner leaves the ALU idle.
    assign elig0 = bus.req0_valid & (~own_q | ~own_id_q);
    assign elig1 = bus.req1_valid & (~own_q | own_id_q);
`else
    assign elig0 = bus.req0_valid;
    assign elig1 = bus.req1_valid;
`endif

    // Grants are forced low during reset so nothing transfers into a clearing pipeline.
    assign gnt0   = rst_n & elig0 & (~elig1 | ~rr_ptr_q);
    assign gnt1   = rst_n & elig1 & (~elig0 | rr_ptr_q);
    assign xfer   = gnt0 | gnt1;
    assign gnt_id = gnt1;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_comb begin
        bus.alu_op    = '0;
        bus.alu_funct = '0;
        bus.alu_shamt = '0;
        bus.alu_idata = '0;
        bus.alu_reg1  = '0;
        bus.alu_reg2  = '0;
        if (gnt0) begin
            bus.alu_op    = bus.req0_op;
            bus.alu_funct = bus.req0_funct;
            bus.alu_shamt = bus.req0_shamt;
            bus.alu_idata = bus.req0_idata;
            bus.alu_reg1  = bus.req0_reg1;
            bus.alu_reg2  = bus.req0_reg2;
        end else if (gnt1) begin
            bus.alu_op    = bus.req1_op;
            bus.alu_funct = bus.req1_funct;
            bus.alu_shamt = bus.req1_shamt;
            bus.alu_idata = bus.req1_idata;
            bus.alu_reg1  = bus.req1_reg1;
            bus.alu_reg2  = bus.req1_reg2;
        end
    end

    // Legal space: 00_000..00_110 and 01_000..01_011.
    always_comb begin
        legal = 1'b0;
        unique case (bus.alu_op)
            2'b00:   legal = (bus.alu_funct != 3'b111);
            2'b01:   legal = ~bus.alu_funct[2];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = xfer;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (xfer) begin
            rr_ptr_d   = ~gnt_id;
            rsp_id_d   = gnt_id;
            rsp_data_d = legal ? bus.alu_out : '0;
            rsp_err_d  = ~legal;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    always_comb begin
        own_d        = own_q;
        own_id_d     = own_id_q;
        lock_cnt_d   = lock_cnt_q;
        gnt_lock     = gnt1 ? bus.req1_lock : bus.req0_lock;
        // A fresh lock counts as the first locked transfer.
        lock_cnt_inc = own_q ? lock_cnt_q + 3'd1 : 3'd1;
        if (xfer) begin
            if (!gnt_lock || ({29'd0, lock_cnt_inc} >= LOCK_MAX)) begin
                own_d      = 1'b0;
                lock_cnt_d = '0;
            end else begin
                own_d      = 1'b1;
                own_id_d   = gnt_id;
                lock_cnt_d = lock_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q      <= 1'b0;
            own_id_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            own_q      <= own_d;
            own_id_q   <= own_id_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= RESET_PTR;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small behavioural ALU model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_arbiter_if #(.DATA_W(16)) bus ();

    alu_arbiter #(.DATA_W(16), .RESET_PTR(1'b0), .LOCK_MAX(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ALU model: 00_000 AND, 00_001 OR, 00_101 ADD, 00_110 XOR, 01_000 LBI, 01_001 LUI,
    // 01_011 MOV reg2; others produce a junk pattern. Result is post-shifted by shamt.
    logic [15:0] alu_raw;
    always_comb begin
        alu_raw = 16'hDEAD;
        case ({bus.alu_op, bus.alu_funct})
            5'b00_000: alu_raw = bus.alu_reg1 & bus.alu_reg2;
            5'b00_001: alu_raw = bus.alu_reg1 | bus.alu_reg2;
            5'b00_101: alu_raw = bus.alu_reg1 + bus.alu_reg2;
            5'b00_110: alu_raw = bus.alu_reg1 ^ bus.alu_reg2;
            5'b01_000: alu_raw = {8'h00, bus.alu_idata};
            5'b01_001: alu_raw = {bus.alu_idata, 8'h00};
            5'b01_011: alu_raw = bus.alu_reg2;
            default:   ;
        endcase
        bus.alu_out = alu_raw << bus.alu_shamt;
    end

    // Command-stability monitor: a pending command must stay valid and unchanged.
    logic [46:0] cmd0, cmd1, held0 = '0, held1 = '0;
    logic        pend0 = 1'b0, pend1 = 1'b0, prot_bad = 1'b0;
    assign cmd0 = {bus.req0_op, bus.req0_funct, bus.req0_shamt, bus.req0_idata,
                   bus.req0_reg1, bus.req0_reg2};
    assign cmd1 = {bus.req1_op, bus.req1_funct, bus.req1_shamt, bus.req1_idata,
                   bus.req1_reg1, bus.req1_reg2};
    always @(posedge clk) begin
        if (pend0 && !(bus.req0_valid && cmd0 == held0)) prot_bad <= 1'b1;
        if (pend1 && !(bus.req1_valid && cmd1 == held1)) prot_bad <= 1'b1;
        pend0 <= rst_n & bus.req0_valid & ~bus.req0_ready;
        pend1 <= rst_n & bus.req1_valid & ~bus.req1_ready;
        held0 <= cmd0;
        held1 <= cmd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int n, input logic v, input logic [4:0] code, input logic [1:0] sh,
                       input logic [7:0] imm, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin
            bus.req0_valid = v;
            {bus.req0_op, bus.req0_funct} = code;
            bus.req0_shamt = sh;
            bus.req0_idata = imm;
            bus.req0_reg1  = a;
            bus.req0_reg2  = b;
        end else begin
            bus.req1_valid = v;
            {bus.req1_op, bus.req1_funct} = code;
            bus.req1_shamt = sh;
            bus.req1_idata = imm;
            bus.req1_reg1  = a;
            bus.req1_reg2  = b;
        end
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_rdy0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
        chk({tag, "_rdy1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id, input logic [15:0] d,
                           input logic e);
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, {31'd0, v});
        chk({tag, "_id"},    {31'd0, bus.rsp_id},    {31'd0, id});
        chk({tag, "_data"},  {16'd0, bus.rsp_data},  {16'd0, d});
        chk({tag, "_err"},   {31'd0, bus.rsp_err},   {31'd0, e});
    endtask

    logic [4:0]  bcode [4];
    logic [15:0] bdata [4];
    logic        berr  [4];

    initial begin
        drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
`ifdef ALU_ARB_LOCK_EN
        bus.req0_lock = 1'b0;
        bus.req1_lock = 1'b0;
`endif
        // Reset with both valid: no grants, cleared response.
        drv(0, 1'b1, 5'b00_000, 2'd0, 8'd0, 16'h00FF, 16'h0F0F);
        drv(1, 1'b1, 5'b00_001, 2'd0, 8'd0, 16'h0001, 16'h0002);
        repeat (2) @(negedge clk);
        #1 chk_rdy("reset", 1'b0, 1'b0);
        chk_rsp("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk_rdy("rel_first", 1'b1, 1'b0);
        @(negedge clk) drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rdy("rel_second", 1'b0, 1'b1);
        chk_rsp("rel_and", 1'b1, 1'b0, 16'h000F, 1'b0);
        @(negedge clk) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("rel_or", 1'b1, 1'b1, 16'h0003, 1'b0);

        // ADD (3+4)<<1 on req0, then an idle cycle holds the response fields.
        @(negedge clk) drv(0, 1'b1, 5'b00_101, 2'd1, 8'd0, 16'h0003, 16'h0004);
        #1 chk_rdy("add", 1'b1, 1'b0);
        @(negedge clk) drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("add", 1'b1, 1'b0, 16'h000E, 1'b0);
        @(negedge clk);
        #1 chk_rsp("idle_hold", 1'b0, 1'b0, 16'h000E, 1'b0);

        // Illegal {01,111} on req1.
        @(negedge clk) drv(1, 1'b1, 5'b01_111, 2'd0, 8'h11, 16'h1234, 16'h5678);
        #1 chk_rdy("illegal", 1'b0, 1'b1);
        @(negedge clk) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("illegal", 1'b1, 1'b1, 16'h0000, 1'b1);

        // Both valid: grants alternate 0,1,0,1 (pointer is 0 here).
        @(negedge clk);
        drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0001, 16'h0002);
        drv(1, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0010, 16'h0020);
        #1 chk_rdy("rr_a", 1'b1, 1'b0);
        @(negedge clk) drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0005, 16'h0005);
        #1 chk_rdy("rr_b", 1'b0, 1'b1);
        chk_rsp("rr_b", 1'b1, 1'b0, 16'h0003, 1'b0);
        @(negedge clk) drv(1, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0100, 16'h0001);
        #1 chk_rdy("rr_c", 1'b1, 1'b0);
        chk_rsp("rr_c", 1'b1, 1'b1, 16'h0030, 1'b0);
        @(negedge clk) drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0007, 16'h0008);
        #1 chk_rdy("rr_d", 1'b0, 1'b1);
        chk_rsp("rr_d", 1'b1, 1'b0, 16'h000A, 1'b0);
        @(negedge clk) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rdy("rr_e", 1'b1, 1'b0);
        chk_rsp("rr_e", 1'b1, 1'b1, 16'h0101, 1'b0);
        @(negedge clk) drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("rr_f", 1'b1, 1'b0, 16'h000F, 1'b0);

        // LBI then LUI back to back on req1.
        @(negedge clk) drv(1, 1'b1, 5'b01_000, 2'd0, 8'hA5, 16'h1111, 16'h2222);
        #1 chk_rdy("lbi", 1'b0, 1'b1);
        @(negedge clk) drv(1, 1'b1, 5'b01_001, 2'd0, 8'hA5, 16'h1111, 16'h2222);
        #1 chk_rdy("lui", 1'b0, 1'b1);
        chk_rsp("lbi", 1'b1, 1'b1, 16'h00A5, 1'b0);
        @(negedge clk) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("lui", 1'b1, 1'b1, 16'hA500, 1'b0);

        // Legal-range boundaries, streamed on req0.
        bcode = '{5'b00_110, 5'b00_111, 5'b01_011, 5'b10_000};
        bdata = '{16'h0F00, 16'h0000, 16'h0FF0, 16'h0000};
        berr  = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) drv(0, 1'b1, bcode[i], 2'd0, 8'd0, 16'h00F0, 16'h0FF0);
            else       drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
            #1;
            if (i > 0) chk_rsp($sformatf("bound%0d", i - 1), 1'b1, 1'b0, bdata[i-1], berr[i-1]);
        end

        // Reset right after a transfer: response dropped, pointer back to 0.
        @(negedge clk) drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0001, 16'h0001);
        #1 chk_rdy("pre_rst", 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("mid_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0002, 16'h0002);
        drv(1, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0003, 16'h0003);
        #1 chk_rdy("post_rst", 1'b1, 1'b0);
        @(negedge clk) drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rdy("post_rst2", 1'b0, 1'b1);
        chk_rsp("post_rst", 1'b1, 1'b0, 16'h0004, 1'b0);
        @(negedge clk) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
        #1 chk_rsp("post_rst2", 1'b1, 1'b1, 16'h0006, 1'b0);

`ifdef ALU_ARB_LOCK_EN
        // req0 locked for 6 cycles against a waiting req1: grants 0,0,0,0,1,0.
        @(negedge clk);
        bus.req0_lock = 1'b1;
        drv(0, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0001, 16'h0001);
        drv(1, 1'b1, 5'b00_101, 2'd0, 8'd0, 16'h0002, 16'h0002);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) drv(1, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
            #1 chk_rdy($sformatf("lock%0d", i), (i != 4), (i == 4));
        end
        @(negedge clk);
        bus.req0_lock = 1'b0;
        drv(0, 1'b0, 5'd0, 2'd0, 8'd0, 16'd0, 16'd0);
`endif

        @(negedge clk);
        chk("protocol", {31'd0, prot_bad}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
